// File: rtl/wb_if.sv
// Wishbone classic single-access bus bundle.
// The master drives the request, the slave returns data/ack/err.
interface wb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   wdat;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    we;
    logic                    stb;
    logic                    cyc;
    logic [DATA_WIDTH-1:0]   rdat;
    logic                    ack;
    logic                    err;

    modport master (
        output adr, wdat, sel, we, stb, cyc,
        input  rdat, ack, err
    );

    modport slave (
        input  adr, wdat, sel, we, stb, cyc,
        output rdat, ack, err
    );
endinterface

// File: rtl/wb_regfile.sv
// Wishbone register file: NUM_REGS-1 writable words plus a read-only
// status word at the top index, with programmable wait states.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS = 8,
    parameter int WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    wb_if.slave                               s_wb,
    input  logic [DATA_WIDTH-1:0]             status_i,
    output logic [(NUM_REGS-1)*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-2:0]               wr_pulse_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = $clog2(NUM_REGS);
    localparam int NW = NUM_REGS - 1;
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                       state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]        adr_q, adr_d;
    logic [DATA_WIDTH-1:0]        wdat_q, wdat_d;
    logic [NB-1:0]                sel_q, sel_d;
    logic                         we_q, we_d;
    logic                         ack_q, ack_d;
    logic                         err_q, err_d;
    logic [DATA_WIDTH-1:0]        rdat_q, rdat_d;
    logic [NW-1:0]                pulse_q, pulse_d;
    logic [NW-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

    logic                  req;
    logic [ADDR_WIDTH-1:0] cur_adr;
    logic                  cur_we;
    logic [IW-1:0]         idx;
    logic [SW-1:0]         slot;
    logic                  bad;
    logic                  is_stat;
    logic                  commit_ok;
    logic                  go_resp;
    logic [DATA_WIDTH-1:0] rd_val;

    // In IDLE the decode looks at the live bus so a zero-wait access
    // can be answered on the capture edge; afterwards the latched copy.
    assign req       = s_wb.cyc & s_wb.stb;
    assign cur_adr   = (state_q == IDLE) ? s_wb.adr : adr_q;
    assign cur_we    = (state_q == IDLE) ? s_wb.we : we_q;
    assign idx       = cur_adr[ADDR_WIDTH-1:2];
    assign slot      = cur_adr[2 +: SW];
    assign bad       = (idx >= IW'(NUM_REGS)) || (cur_adr[1:0] != 2'b00);
    assign is_stat   = (idx == IW'(NUM_REGS - 1));
    assign commit_ok = cur_we & ~bad & ~is_stat;

    always_comb begin
        rd_val = '0;
        if (is_stat) begin
            rd_val = status_i;
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (slot == SW'(i)) rd_val = regs_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = '0;
        pulse_d = '0;
        regs_d  = regs_q;
        go_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    adr_d  = s_wb.adr;
                    wdat_d = s_wb.wdat;
                    sel_d  = s_wb.sel;
                    we_d   = s_wb.we;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (commit_ok) begin
                    for (int i = 0; i < NW; i++) begin
                        if (slot == SW'(i)) begin
                            for (int b = 0; b < NB; b++) begin
                                if (sel_q[b]) begin
                                    regs_d[i][8*b +: 8] = wdat_q[8*b +: 8];
                                end
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (go_resp) begin
            ack_d = 1'b1;
            err_d = bad;
            if (!bad && !cur_we) rdat_d = rd_val;
            for (int i = 0; i < NW; i++) begin
                if (slot == SW'(i)) pulse_d[i] = commit_ok;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            pulse_q <= '0;
            regs_q  <= {NW{RESET_VAL}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            pulse_q <= pulse_d;
            regs_q  <= regs_d;
        end
    end

    assign s_wb.ack   = ack_q;
    assign s_wb.err   = err_q;
    assign s_wb.rdat  = rdat_q;
    assign wr_pulse_o = pulse_q;
    assign regs_o     = regs_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: vector table with scoreboard on a one-wait-state
// instance, hand sequences for abort and reset on a three-wait-state one.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic [31:0] status1 = 32'hCAFE0001;
    logic [31:0] status3 = 32'h0;
    logic [223:0] regs1, regs3;
    logic [6:0] pulse1, pulse3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
    wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus3 ();

    wb_regfile #(.NUM_REGS(8), .WAIT_STATES(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .s_wb(bus1),
        .status_i(status1), .regs_o(regs1), .wr_pulse_o(pulse1)
    );

    wb_regfile #(.NUM_REGS(8), .WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_i(rst_i), .s_wb(bus3),
        .status_i(status3), .regs_o(regs3), .wr_pulse_o(pulse3)
    );

    typedef struct {
        logic [31:0] rdat;
        logic        err;
        logic [6:0]  pulse;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        exp_t        e;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[16];
    logic [31:0] model[2][7];

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic we, input logic [31:0] adr,
                         input logic [31:0] wdat, input logic [3:0] sel,
                         input logic go);
        if (d == 0) begin
            bus1.we = we; bus1.adr = adr; bus1.wdat = wdat;
            bus1.sel = sel; bus1.stb = go; bus1.cyc = go;
        end else begin
            bus3.we = we; bus3.adr = adr; bus3.wdat = wdat;
            bus3.sel = sel; bus3.stb = go; bus3.cyc = go;
        end
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? bus1.ack : bus3.ack;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? bus1.err : bus3.err;
    endfunction
    function automatic logic [31:0] get_rdat(input int d);
        return (d == 0) ? bus1.rdat : bus3.rdat;
    endfunction
    function automatic logic [6:0] get_pulse(input int d);
        return (d == 0) ? pulse1 : pulse3;
    endfunction
    function automatic logic [223:0] get_regs(input int d);
        return (d == 0) ? regs1 : regs3;
    endfunction

    function automatic logic [223:0] model_flat(input int d);
        logic [223:0] f;
        for (int i = 0; i < 7; i++) f[i*32 +: 32] = model[d][i];
        return f;
    endfunction

    task automatic xact(input int d, input logic we, input logic [31:0] adr,
                        input logic [31:0] wdat, input logic [3:0] sel,
                        input exp_t e, input int lat);
        int got;
        logic [31:0] r;
        logic er;
        logic [6:0] p;
        exp_t x;
        @(posedge clk); #1;
        sbq.push_back(e);
        drive(d, we, adr, wdat, sel, 1'b1);
        got = 0;
        r = '0; er = 1'b0; p = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (get_ack(d)) begin
                got = k; r = get_rdat(d); er = get_err(d); p = get_pulse(d);
                break;
            end
        end
        drive(d, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("latency", got, lat);
        x = sbq.pop_front();
        if (got != 0) begin
            chk("rdat", r, x.rdat);
            chk("err", er, x.err);
            chk("wr_pulse", p, x.pulse);
        end
        if (we && !e.err && adr[31:2] < 7) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model[d][adr[4:2]][8*b +: 8] = wdat[8*b +: 8];
        end
        @(posedge clk); #1;
        chk("ack_single", get_ack(d), 1'b0);
        chk("pulse_single", get_pulse(d), 7'h0);
        chk("regs_o", get_regs(d), model_flat(d));
    endtask

    initial begin
        int acks, first, consec;
        logic prev;
        exp_t e;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 7; i++) model[d][i] = 32'h0;

        vt[0]  = '{1'b0, 32'h04, 32'h0,        4'h0, '{32'h0,        1'b0, 7'h00}};
        vt[1]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, '{32'h0,        1'b0, 7'h02}};
        vt[2]  = '{1'b0, 32'h04, 32'h0,        4'h0, '{32'hDEADBEEF, 1'b0, 7'h00}};
        vt[3]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, '{32'h0,        1'b0, 7'h04}};
        vt[4]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, '{32'h0,        1'b0, 7'h04}};
        vt[5]  = '{1'b0, 32'h08, 32'h0,        4'h0, '{32'h11BB33DD, 1'b0, 7'h00}};
        vt[6]  = '{1'b0, 32'h20, 32'h0,        4'h0, '{32'h0,        1'b1, 7'h00}};
        vt[7]  = '{1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, '{32'h0,        1'b1, 7'h00}};
        vt[8]  = '{1'b0, 32'h1C, 32'h0,        4'h0, '{32'hCAFE0001, 1'b0, 7'h00}};
        vt[9]  = '{1'b1, 32'h1C, 32'h12345678, 4'hF, '{32'h0,        1'b0, 7'h00}};
        vt[10] = '{1'b0, 32'h1C, 32'h0,        4'h0, '{32'hCAFE0001, 1'b0, 7'h00}};
        vt[11] = '{1'b1, 32'h00, 32'h00000055, 4'h0, '{32'h0,        1'b0, 7'h01}};
        vt[12] = '{1'b0, 32'h00, 32'h0,        4'h0, '{32'h0,        1'b0, 7'h00}};
        vt[13] = '{1'b1, 32'h18, 32'h01020304, 4'h3, '{32'h0,        1'b0, 7'h40}};
        vt[14] = '{1'b0, 32'h18, 32'h0,        4'h0, '{32'h00000304, 1'b0, 7'h00}};
        vt[15] = '{1'b0, 32'h04, 32'h0,        4'h0, '{32'hDEADBEEF, 1'b0, 7'h00}};

        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        #1 rst_i = 1'b1;
        #2;
        chk("rst_ack", bus1.ack, 1'b0);
        chk("rst_err", bus1.err, 1'b0);
        chk("rst_rdat", bus1.rdat, 32'h0);
        chk("rst_pulse", pulse1, 7'h0);
        chk("rst_regs1", regs1, 224'h0);
        chk("rst_regs3", regs3, 224'h0);
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk); #1;
        chk("release_ack", bus1.ack, 1'b0);

        for (int i = 0; i < 16; i++)
            xact(0, vt[i].we, vt[i].adr, vt[i].wdat, vt[i].sel, vt[i].e, 2);

        // abort: stb dropped during the wait phase of the slow instance
        @(posedge clk); #1;
        drive(1, 1'b1, 32'h04, 32'h12345678, 4'hF, 1'b1);
        @(posedge clk); #1;
        chk("abort_ack_c1", bus3.ack, 1'b0);
        @(posedge clk); #1;
        chk("abort_ack_c2", bus3.ack, 1'b0);
        bus3.stb = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            @(posedge clk); #1;
            chk("abort_ack", bus3.ack, 1'b0);
            chk("abort_pulse", pulse3, 7'h0);
        end
        bus3.cyc = 1'b0;
        chk("abort_regs", regs3, 224'h0);
        e = '{32'h0, 1'b0, 7'h02};
        xact(1, 1'b1, 32'h04, 32'hA5A5A5A5, 4'hF, e, 4);
        e = '{32'h0, 1'b0, 7'h04};
        xact(1, 1'b1, 32'h08, 32'h0BADF00D, 4'hF, e, 4);

        // reset in the middle of a wait phase
        @(posedge clk); #1;
        drive(1, 1'b1, 32'h08, 32'h77777777, 4'hF, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_i = 1'b1;
        #1;
        chk("midrst_ack", bus3.ack, 1'b0);
        chk("midrst_reg2", regs3[64 +: 32], 32'h0);
        chk("midrst_regs1", regs1, 224'h0);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 7; i++) model[d][i] = 32'h0;
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_i = 1'b0;
        status1 = 32'h5A5A0003;
        drive(0, 1'b0, 32'h1C, 32'h0, 4'h0, 1'b1);
        acks = 0; first = 0; consec = 0; prev = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (bus1.ack) begin
                acks++;
                if (first == 0) first = k;
                if (prev) consec++;
                chk("stream_rdat", bus1.rdat, 32'h5A5A0003);
            end
            prev = bus1.ack;
        end
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("stream_first", first, 2);
        chk("stream_acks", acks, 4);
        chk("stream_consec", consec, 0);
        chk("post_rst_regs3", regs3, 224'h0);
        e = '{32'h0, 1'b0, 7'h00};
        xact(1, 1'b0, 32'h08, 32'h0, 4'h0, e, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
